// File: rtl/udp_tx_pkt_fifo_if.sv
// Write/read handshake bundle for the UDP transmit packet FIFO.
// The master drives writes, reads and thresholds; the slave is the FIFO itself.
interface udp_tx_pkt_fifo_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 7
);
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  wr_en;
   logic                  wr_last;
   logic                  wr_drop;
   logic [ADDR_WIDTH:0]   af_thresh;
   logic [ADDR_WIDTH:0]   ae_thresh;
   logic                  full;
   logic                  almost_full;
   logic                  overflow;
   logic [ADDR_WIDTH:0]   wr_count;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_last;
   logic                  rd_valid;
   logic                  empty;
   logic                  almost_empty;
   logic                  underflow;
   logic [ADDR_WIDTH:0]   rd_count;
   logic [ADDR_WIDTH:0]   pkt_count;

   modport master (
      output wr_data, wr_en, wr_last, wr_drop, af_thresh, ae_thresh, rd_en,
      input  full, almost_full, overflow, wr_count, rd_data, rd_last, rd_valid,
             empty, almost_empty, underflow, rd_count, pkt_count
   );

   modport slave (
      input  wr_data, wr_en, wr_last, wr_drop, af_thresh, ae_thresh, rd_en,
      output full, almost_full, overflow, wr_count, rd_data, rd_last, rd_valid,
             empty, almost_empty, underflow, rd_count, pkt_count
   );
endinterface

// File: rtl/udp_tx_pkt_fifo.sv
// Synchronous FIFO with packet commit/drop gating for the UDP transmit path.
// Words become readable only once their packet's last word is committed.
module udp_tx_pkt_fifo #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 7,
   parameter int unsigned OUT_REG    = 1,
   parameter int unsigned PKT_MODE   = 1
) (
   input logic              clk,
   input logic              rst,
   udp_tx_pkt_fifo_if.slave bus
);
   localparam int unsigned        Depth    = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DepthCnt = (ADDR_WIDTH + 1)'(Depth);
   localparam bit                 PktMode  = (PKT_MODE != 0);

   logic [DATA_WIDTH:0] mem [Depth];

   logic [ADDR_WIDTH:0] wr_ptr, cmt_ptr, rd_ptr, pkt_cnt;
   logic [ADDR_WIDTH:0] wr_cnt, rd_cnt;
   logic                bad_pkt, ovf_q, udf_q;
   logic                full, empty, drop;
   logic                wr_acc, wr_rej, rd_acc, rd_is_last, commit, pkt_dec;

   assign wr_cnt = wr_ptr - rd_ptr;
   assign rd_cnt = cmt_ptr - rd_ptr;
   assign full   = (wr_cnt == DepthCnt);
   assign empty  = (rd_cnt == '0);

   // Drop beats a same-cycle write, and only exists in packet mode.
   assign drop       = PktMode && bus.wr_drop;
   assign wr_acc     = bus.wr_en && !full && !drop;
   assign wr_rej     = bus.wr_en && full && !drop;
   assign rd_acc     = bus.rd_en && !empty;
   assign rd_is_last = mem[rd_ptr[ADDR_WIDTH-1:0]][DATA_WIDTH];
   assign commit     = wr_acc && bus.wr_last && !bad_pkt;
   assign pkt_dec    = rd_acc && rd_is_last;

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr[ADDR_WIDTH-1:0]] <= {bus.wr_last, bus.wr_data};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         cmt_ptr <= '0;
         rd_ptr  <= '0;
         pkt_cnt <= '0;
         bad_pkt <= 1'b0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         ovf_q <= wr_rej;
         udf_q <= bus.rd_en && empty;
         if (rd_acc) rd_ptr <= rd_ptr + 1'b1;

         if (!PktMode) begin
            if (wr_acc) begin
               wr_ptr  <= wr_ptr + 1'b1;
               cmt_ptr <= wr_ptr + 1'b1;
            end
         end else if (drop) begin
            wr_ptr  <= cmt_ptr;
            bad_pkt <= 1'b0;
         end else if (wr_rej) begin
            // A rejected last word still closes the (now broken) packet.
            if (bus.wr_last) begin
               wr_ptr  <= cmt_ptr;
               bad_pkt <= 1'b0;
            end else begin
               bad_pkt <= 1'b1;
            end
         end else if (wr_acc) begin
            if (!bus.wr_last) begin
               wr_ptr <= wr_ptr + 1'b1;
            end else if (bad_pkt) begin
               wr_ptr  <= cmt_ptr;
               bad_pkt <= 1'b0;
            end else begin
               wr_ptr  <= wr_ptr + 1'b1;
               cmt_ptr <= wr_ptr + 1'b1;
            end
         end

         if (commit && !pkt_dec) begin
            pkt_cnt <= pkt_cnt + 1'b1;
         end else if (!commit && pkt_dec) begin
            pkt_cnt <= pkt_cnt - 1'b1;
         end
      end
   end

   logic [DATA_WIDTH-1:0] s1_data;
   logic                  s1_last, s1_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_data  <= '0;
         s1_last  <= 1'b0;
         s1_valid <= 1'b0;
      end else begin
         s1_valid <= rd_acc;
         if (rd_acc) {s1_last, s1_data} <= mem[rd_ptr[ADDR_WIDTH-1:0]];
      end
   end

   if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] s2_data;
      logic                  s2_last, s2_valid;

      always_ff @(posedge clk) begin
         if (rst) begin
            s2_data  <= '0;
            s2_last  <= 1'b0;
            s2_valid <= 1'b0;
         end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               s2_data <= s1_data;
               s2_last <= s1_last;
            end
         end
      end

      assign bus.rd_data  = s2_data;
      assign bus.rd_last  = s2_last;
      assign bus.rd_valid = s2_valid;
   end else begin : g_no_out_reg
      assign bus.rd_data  = s1_data;
      assign bus.rd_last  = s1_last;
      assign bus.rd_valid = s1_valid;
   end

   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.wr_count     = wr_cnt;
   assign bus.rd_count     = rd_cnt;
   assign bus.pkt_count    = pkt_cnt;
   assign bus.almost_full  = (wr_cnt >= bus.af_thresh);
   assign bus.almost_empty = (rd_cnt <= bus.ae_thresh);
   assign bus.overflow     = ovf_q;
   assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_udp_tx_pkt_fifo.sv
// Scoreboard bench: dut_a is packet mode with output register, dut_b is plain
// FIFO mode with single-cycle read latency; both share clock and reset.
module tb_udp_tx_pkt_fifo;
   typedef struct {
      logic [7:0] d;
      logic       l;
      int         due;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   exp_t qa[$];
   exp_t qb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   udp_tx_pkt_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if_a ();
   udp_tx_pkt_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if_b ();

   udp_tx_pkt_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .OUT_REG(1), .PKT_MODE(1)) dut_a (
      .clk(clk), .rst(rst), .bus(if_a)
   );
   udp_tx_pkt_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .OUT_REG(0), .PKT_MODE(0)) dut_b (
      .clk(clk), .rst(rst), .bus(if_b)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic mon(input int s, input logic [7:0] d, input logic l);
      exp_t  e;
      string nm;
      bit    have;
      nm = (s == 0) ? "out_a" : "out_b";
      n_cmp++;
      have = (s == 0) ? (qa.size() != 0) : (qb.size() != 0);
      if (!have) begin
         n_err++;
         $display("FAIL %s: unexpected word data=%h last=%b at cycle %0d", nm, d, l, cyc);
      end else begin
         if (s == 0) e = qa.pop_front();
         else        e = qb.pop_front();
         if (d !== e.d || l !== e.l || cyc != e.due) begin
            n_err++;
            $display("FAIL %s: got data=%h last=%b cycle=%0d expected data=%h last=%b cycle=%0d",
                     nm, d, l, cyc, e.d, e.l, e.due);
         end
      end
   endtask

   always @(negedge clk) begin
      if (if_a.rd_valid === 1'b1) mon(0, if_a.rd_data, if_a.rd_last);
      if (if_b.rd_valid === 1'b1) mon(1, if_b.rd_data, if_b.rd_last);
   end

   // One clock of stimulus on fifo s; a pushed read expects its word LAT cycles on.
   task automatic cyc1(input int s, input bit we, input logic [7:0] d, input bit l,
                       input bit dr, input bit re, input bit push,
                       input logic [7:0] ed, input bit el);
      exp_t e;
      if (s == 0) begin
         if_a.wr_en = we; if_a.wr_data = d; if_a.wr_last = l; if_a.wr_drop = dr;
         if_a.rd_en = re;
      end else begin
         if_b.wr_en = we; if_b.wr_data = d; if_b.wr_last = l; if_b.wr_drop = dr;
         if_b.rd_en = re;
      end
      if (push) begin
         e.d = ed;
         e.l = el;
         e.due = cyc + ((s == 0) ? 2 : 1);
         if (s == 0) qa.push_back(e);
         else        qb.push_back(e);
      end
      @(posedge clk);
      #1;
      if_a.wr_en = 0; if_a.wr_last = 0; if_a.wr_drop = 0; if_a.rd_en = 0;
      if_b.wr_en = 0; if_b.wr_last = 0; if_b.wr_drop = 0; if_b.rd_en = 0;
   endtask

   task automatic wr(input int s, input logic [7:0] d, input bit l);
      cyc1(s, 1, d, l, 0, 0, 0, 8'h00, 0);
   endtask
   task automatic wrd(input int s, input logic [7:0] d, input bit l);
      cyc1(s, 1, d, l, 1, 0, 0, 8'h00, 0);
   endtask
   task automatic rd(input int s, input logic [7:0] ed, input bit el);
      cyc1(s, 0, 8'h00, 0, 0, 1, 1, ed, el);
   endtask
   task automatic rdx(input int s);
      cyc1(s, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0);
   endtask
   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc1(0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      if_a.wr_data = 0; if_a.wr_en = 0; if_a.wr_last = 0; if_a.wr_drop = 0; if_a.rd_en = 0;
      if_b.wr_data = 0; if_b.wr_en = 0; if_b.wr_last = 0; if_b.wr_drop = 0; if_b.rd_en = 0;
      if_a.af_thresh = 5'd14; if_a.ae_thresh = 5'd2;
      if_b.af_thresh = 5'd16; if_b.ae_thresh = 5'd0;

      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      chk("rst_full", if_a.full, 0);
      chk("rst_empty", if_a.empty, 1);
      chk("rst_afull", if_a.almost_full, 0);
      chk("rst_aempty", if_a.almost_empty, 1);
      chk("rst_valid", if_a.rd_valid, 0);
      chk("rst_ovf", if_a.overflow, 0);
      chk("rst_udf", if_a.underflow, 0);
      chk("rst_data", if_a.rd_data, 0);
      chk("rst_last", if_a.rd_last, 0);
      chk("rst_wr_count", if_a.wr_count, 0);
      chk("rst_pkt_count", if_a.pkt_count, 0);

      // Packet invisible until its last word is written.
      for (int i = 0; i < 4; i++) begin
         wr(0, 8'(16 + i), 0);
         chk("t1_empty_open", if_a.empty, 1);
      end
      wr(0, 8'h14, 1);
      chk("t1_empty_cmt", if_a.empty, 0);
      chk("t1_rd_count", if_a.rd_count, 5);
      chk("t1_pkt_count", if_a.pkt_count, 1);
      for (int i = 0; i < 5; i++) rd(0, 8'(16 + i), (i == 4));
      chk("t1_pkt_after", if_a.pkt_count, 0);
      chk("t1_empty_after", if_a.empty, 1);
      idle(3);

      // Drop together with a write; drop also beats a last word.
      wr(0, 8'h20, 0); wr(0, 8'h21, 0); wr(0, 8'h22, 0);
      chk("t2_wr_count_open", if_a.wr_count, 3);
      wrd(0, 8'h23, 0);
      chk("t2_wr_count_drop", if_a.wr_count, 0);
      chk("t2_empty_drop", if_a.empty, 1);
      wr(0, 8'h40, 0);
      wrd(0, 8'h41, 1);
      chk("t2_wr_count_droplast", if_a.wr_count, 0);
      chk("t2_pkt_droplast", if_a.pkt_count, 0);
      wr(0, 8'h30, 0); wr(0, 8'h31, 1);
      chk("t2_pkt", if_a.pkt_count, 1);
      rd(0, 8'h30, 0); rd(0, 8'h31, 1);
      idle(3);

      // Overflow of an uncommitted packet, rewound by the rejected last word.
      for (int i = 0; i < 16; i++) wr(0, 8'(8'h50 + i), 0);
      chk("t3_full", if_a.full, 1);
      chk("t3_wr_count", if_a.wr_count, 16);
      chk("t3_empty", if_a.empty, 1);
      wr(0, 8'h60, 0);
      chk("t3_ovf", if_a.overflow, 1);
      chk("t3_wr_count_ovf", if_a.wr_count, 16);
      idle(1);
      chk("t3_ovf_pulse", if_a.overflow, 0);
      wr(0, 8'h61, 1);
      chk("t3_rewind", if_a.wr_count, 0);
      chk("t3_rewind_full", if_a.full, 0);
      chk("t3_rewind_pkt", if_a.pkt_count, 0);

      // Broken packet whose last word is accepted after a read frees space.
      wr(0, 8'h70, 0); wr(0, 8'h71, 1);
      for (int i = 0; i < 14; i++) wr(0, 8'(8'h72 + i), 0);
      chk("t3b_full", if_a.full, 1);
      wr(0, 8'hEE, 0);
      chk("t3b_ovf", if_a.overflow, 1);
      rd(0, 8'h70, 0);
      wr(0, 8'hEF, 1);
      chk("t3b_wr_count", if_a.wr_count, 1);
      chk("t3b_rd_count", if_a.rd_count, 1);
      chk("t3b_pkt", if_a.pkt_count, 1);
      rd(0, 8'h71, 1);
      chk("t3b_pkt_after", if_a.pkt_count, 0);
      idle(3);

      // Threshold sweep with one-word packets.
      if_a.af_thresh = 5'd12; if_a.ae_thresh = 5'd3;
      for (int i = 1; i <= 16; i++) begin
         wr(0, 8'(128 + i), 1);
         chk("t5_afull_up", if_a.almost_full, (i >= 12));
         chk("t5_aempty_up", if_a.almost_empty, (i <= 3));
      end
      chk("t5_full", if_a.full, 1);
      chk("t5_pkt", if_a.pkt_count, 16);
      for (int j = 1; j <= 16; j++) begin
         rd(0, 8'(128 + j), 1);
         chk("t5_afull_dn", if_a.almost_full, ((16 - j) >= 12));
         chk("t5_aempty_dn", if_a.almost_empty, ((16 - j) <= 3));
      end
      chk("t5_pkt_after", if_a.pkt_count, 0);
      idle(3);

      // Reset while a read is in the output pipeline.
      wr(0, 8'h90, 0); wr(0, 8'h91, 1); wr(0, 8'h92, 1);
      chk("t6_pkt", if_a.pkt_count, 2);
      if_a.af_thresh = 5'd0;
      rdx(0);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      chk("t6_wr_count", if_a.wr_count, 0);
      chk("t6_rd_count", if_a.rd_count, 0);
      chk("t6_pkt_count", if_a.pkt_count, 0);
      chk("t6_empty", if_a.empty, 1);
      chk("t6_valid", if_a.rd_valid, 0);
      chk("t6_afull_zero", if_a.almost_full, 1);
      rdx(0);
      chk("t6_udf", if_a.underflow, 1);
      idle(1);
      chk("t6_udf_pulse", if_a.underflow, 0);

      // Plain FIFO mode: fill, read+write at full, then stream across the wrap.
      for (int i = 0; i < 16; i++) wr(1, 8'(8'hA0 + i), (i == 3 || i == 15));
      chk("t4_full", if_b.full, 1);
      chk("t4_rd_count", if_b.rd_count, 16);
      chk("t4_pkt", if_b.pkt_count, 2);
      cyc1(1, 1, 8'hB0, 0, 0, 1, 1, 8'hA0, 0);
      chk("t4_ovf", if_b.overflow, 1);
      chk("t4_wr_count", if_b.wr_count, 15);
      for (int i = 0; i < 20; i++) begin
         if (i < 15) cyc1(1, 1, 8'(8'hC0 + i), 0, 0, 1, 1, 8'(8'hA1 + i), (i == 2 || i == 14));
         else        cyc1(1, 1, 8'(8'hC0 + i), 0, 0, 1, 1, 8'(8'hC0 + i - 15), 0);
      end
      chk("t4_wr_count_stream", if_b.wr_count, 15);
      chk("t4_pkt_stream", if_b.pkt_count, 0);
      for (int i = 0; i < 15; i++) rd(1, 8'(8'hC5 + i), 0);
      chk("t4_empty", if_b.empty, 1);
      wrd(1, 8'hE0, 1);
      chk("t4_drop_ignored", if_b.wr_count, 1);
      chk("t4_drop_pkt", if_b.pkt_count, 1);
      rd(1, 8'hE0, 1);
      idle(5);

      chk("drain_a", qa.size(), 0);
      chk("drain_b", qb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
